// File: rtl/replace_num_table.sv
// replace_num_table: replacement-number store with per-entry valid flag.
// A RAM init sweep runs after reset and on flush. Reads in consume mode queue
// a clear of the entry's valid flag, and the clear is committed in a later
// idle write slot. A later write to the same address cancels that clear.
module replace_num_table #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int CLR_DEPTH  = 2,
    parameter bit STICKY     = 1'b0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  clr_ovf
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {SWEEP, RUN} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   sweep_cnt, cnt_nxt;

    // Storage word: valid flag in the MSB, replacement data below it.
    logic [DATA_WIDTH:0]     mem [DEPTH];
    logic [DATA_WIDTH:0]     rd_word;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [DATA_WIDTH:0]     ram_wdata;

    // Pending-clear queue, kept compacted with the oldest entry in slot 0.
    logic [CLR_DEPTH-1:0]    q_vld, nq_vld;
    logic [ADDR_WIDTH-1:0]   q_addr  [CLR_DEPTH];
    logic [ADDR_WIDTH-1:0]   nq_addr [CLR_DEPTH];
    logic                    ovf_set;

    logic run, wr_acc, rd_acc, pop, hit, push_req;
    int   rank;

    assign run     = (state == RUN);
    assign busy    = (state == SWEEP);
    assign wr_acc  = run && wr_en;
    assign rd_acc  = run && rd_en;
    assign pop     = run && !wr_en && q_vld[0];
    assign rd_word = mem[rd_addr];

    // State and sweep counter register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= cnt_nxt;
        end
    end

    // Next state: the sweep walks every address once, and flush restarts it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = sweep_cnt;
        case (state)
            SWEEP: begin
                if (flush) begin
                    cnt_nxt = '0;
                end else if (sweep_cnt == '1) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = sweep_cnt + 1'b1;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = SWEEP;
        endcase
    end

    // Single RAM write port: sweep has priority, then the user write, then the queued clear.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = sweep_cnt;
        ram_wdata = '0;
        if (!run) begin
            ram_we = 1'b1;
        end else if (wr_en) begin
            ram_we    = 1'b1;
            ram_waddr = wr_addr;
            ram_wdata = {1'b1, wr_data};
        end else if (q_vld[0]) begin
            ram_we    = 1'b1;
            ram_waddr = q_addr[0];
        end
    end

    // RAM write. Reads see the pre-write contents (read-first).
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // Queue update: drop the issued head and any superseded entries, compact the rest, then append the read.
    always_comb begin
        hit     = 1'b0;
        nq_vld  = '0;
        ovf_set = 1'b0;
        rank    = 0;
        for (int j = 0; j < CLR_DEPTH; j++) begin
            nq_addr[j] = '0;
        end
        for (int i = 0; i < CLR_DEPTH; i++) begin
            if (q_vld[i] && q_addr[i] == rd_addr) begin
                hit = 1'b1;
            end
        end
        for (int i = 0; i < CLR_DEPTH; i++) begin
            if (q_vld[i] && !(i == 0 && pop) && !(wr_acc && q_addr[i] == wr_addr)) begin
                for (int j = 0; j < CLR_DEPTH; j++) begin
                    if (j == rank) begin
                        nq_vld[j]  = 1'b1;
                        nq_addr[j] = q_addr[i];
                    end
                end
                rank = rank + 1;
            end
        end
        // A same-cycle write to the read address cancels the clear before it is queued.
        push_req = rd_acc && !STICKY && !hit && !(wr_acc && wr_addr == rd_addr);
        if (push_req) begin
            if (rank < CLR_DEPTH) begin
                for (int j = 0; j < CLR_DEPTH; j++) begin
                    if (j == rank) begin
                        nq_vld[j]  = 1'b1;
                        nq_addr[j] = rd_addr;
                    end
                end
            end else begin
                ovf_set = 1'b1;
            end
        end
        if (flush) begin
            nq_vld = '0;
        end
    end

    // Queue valid bits and the sticky overflow flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q_vld   <= '0;
            clr_ovf <= 1'b0;
        end else begin
            q_vld   <= nq_vld;
            clr_ovf <= flush ? 1'b0 : (clr_ovf | ovf_set);
        end
    end

    // Queue addresses are meaningful only when the matching valid bit is set.
    always_ff @(posedge clk) begin
        q_addr <= nq_addr;
    end

    // Read register. A pending clear masks the valid flag; reads during a sweep return zero.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (rd_en) begin
            if (!run) begin
                data_out  <= '0;
                valid_out <= 1'b0;
            end else begin
                data_out  <= rd_word[DATA_WIDTH-1:0];
                valid_out <= rd_word[DATA_WIDTH] & ~hit;
            end
        end
    end

endmodule

// File: tb/tb_replace_num_table.sv
// Scoreboard bench for replace_num_table.
// Instance dut0 runs in consume mode and instance dut1 runs in sticky mode.
module tb_replace_num_table;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CD = 2;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic          wr_en0, rd_en0, flush0, valid_out0, busy0, clr_ovf0;
    logic [AW-1:0] wr_addr0, rd_addr0;
    logic [DW-1:0] wr_data0, data_out0;
    logic          wr_en1, rd_en1, flush1, valid_out1, busy1, clr_ovf1;
    logic [AW-1:0] wr_addr1, rd_addr1;
    logic [DW-1:0] wr_data1, data_out1;

    replace_num_table #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLR_DEPTH(CD), .STICKY(1'b0)) dut0 (
        .clk(clk), .nrst(nrst), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .flush(flush0), .data_out(data_out0),
        .valid_out(valid_out0), .busy(busy0), .clr_ovf(clr_ovf0));

    replace_num_table #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLR_DEPTH(CD), .STICKY(1'b1)) dut1 (
        .clk(clk), .nrst(nrst), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .flush(flush1), .data_out(data_out1),
        .valid_out(valid_out1), .busy(busy1), .clr_ovf(clr_ovf1));

    typedef struct {
        string         name;
        logic [DW-1:0] data;
        logic          valid;
        bit            chk_data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_s0, mon_s1;
    int   nb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a read sampled at an edge produces output just after that edge.
    always @(posedge clk) begin
        exp_t e;
        mon_s0 = rd_en0;
        mon_s1 = rd_en1;
        #1;
        if (mon_s0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_read: got a read output, expected none queued");
            end else begin
                e = q0.pop_front();
                chk({e.name, "_valid"}, 32'(valid_out0), 32'(e.valid));
                if (e.chk_data) chk({e.name, "_data"}, 32'(data_out0), 32'(e.data));
            end
        end
        if (mon_s1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_read: got a read output, expected none queued");
            end else begin
                e = q1.pop_front();
                chk({e.name, "_valid"}, 32'(valid_out1), 32'(e.valid));
                if (e.chk_data) chk({e.name, "_data"}, 32'(data_out1), 32'(e.data));
            end
        end
    end

    task automatic d0(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic re, input logic [AW-1:0] ra, input logic fl);
        @(negedge clk);
        wr_en0 = we; wr_addr0 = wa; wr_data0 = wd;
        rd_en0 = re; rd_addr0 = ra; flush0 = fl;
    endtask

    task automatic idle0();
        d0(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        d0(1'b1, a, d, 1'b0, '0, 1'b0);
    endtask

    task automatic rd0(input string n, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic v, input bit cd);
        q0.push_back('{name: n, data: d, valid: v, chk_data: cd});
        d0(1'b0, '0, '0, 1'b1, a, 1'b0);
    endtask

    task automatic wrrd0(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input string n,
                         input logic [AW-1:0] ra, input logic [DW-1:0] d, input logic v, input bit cd);
        q0.push_back('{name: n, data: d, valid: v, chk_data: cd});
        d0(1'b1, wa, wd, 1'b1, ra, 1'b0);
    endtask

    task automatic d1(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic re, input logic [AW-1:0] ra);
        @(negedge clk);
        wr_en1 = we; wr_addr1 = wa; wr_data1 = wd;
        rd_en1 = re; rd_addr1 = ra;
    endtask

    task automatic rd1(input string n, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic v);
        q1.push_back('{name: n, data: d, valid: v, chk_data: 1'b1});
        d1(1'b0, '0, '0, 1'b1, a);
    endtask

    // Counts edges until busy falls, bounded so the run always ends.
    task automatic measure_busy(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy0 && n < 100);
    endtask

    initial begin
        nrst = 1'b0;
        wr_en0 = 0; wr_addr0 = '0; wr_data0 = '0; rd_en0 = 0; rd_addr0 = '0; flush0 = 0;
        wr_en1 = 0; wr_addr1 = '0; wr_data1 = '0; rd_en1 = 0; rd_addr1 = '0; flush1 = 0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_data_out", 32'(data_out0), 32'h0);
        chk("rst_valid_out", 32'(valid_out0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h1);
        chk("rst_clr_ovf", 32'(clr_ovf0), 32'h0);
        chk("rst_busy_sticky", 32'(busy1), 32'h1);

        // Init sweep: 16 addresses, so busy falls on the 16th edge after release
        nrst = 1'b1;
        measure_busy(nb);
        chk("init_sweep_edges", 32'(nb), 32'd16);
        chk("init_busy_sticky", 32'(busy1), 32'h0);
        rd0("reset_rd5", 4'd5, 8'h00, 1'b0, 1'b1);

        // Consume
        wr0(4'd3, 8'hA5);
        idle0();
        rd0("consume_rd3_first", 4'd3, 8'hA5, 1'b1, 1'b1);
        idle0();
        rd0("consume_rd3_second", 4'd3, 8'h00, 1'b0, 1'b0);
        idle0();

        // Write-starved clear
        wr0(4'd2, 8'h11);
        rd0("starve_rd2", 4'd2, 8'h11, 1'b1, 1'b1);
        wr0(4'd7, 8'h70);
        wrrd0(4'd8, 8'h80, "starve_rd2_masked", 4'd2, 8'h00, 1'b0, 1'b0);
        wr0(4'd9, 8'h90);
        wr0(4'd7, 8'h71);
        wr0(4'd8, 8'h81);
        idle0();
        rd0("starve_rd2_cleared", 4'd2, 8'h00, 1'b0, 1'b0);
        rd0("starve_rd7", 4'd7, 8'h71, 1'b1, 1'b1);
        rd0("starve_rd8", 4'd8, 8'h81, 1'b1, 1'b1);
        idle0();

        // Supersede: a write after the read, then a write in the same cycle as the read
        rd0("sup_rd1_empty", 4'd1, 8'h00, 1'b0, 1'b1);
        wr0(4'd1, 8'h77);
        idle0();
        rd0("sup_rd1_new", 4'd1, 8'h77, 1'b1, 1'b1);
        idle0();
        wrrd0(4'd1, 8'h78, "sup_samecyc_old", 4'd1, 8'h00, 1'b0, 1'b0);
        idle0();
        rd0("sup_samecyc_new", 4'd1, 8'h78, 1'b1, 1'b1);
        idle0();

        // A full queue that pushes and pops in the same cycle does not overflow
        wr0(4'd4, 8'h44); wr0(4'd5, 8'h55); wr0(4'd6, 8'h66);
        wr0(4'd10, 8'hA0); wr0(4'd11, 8'hB1); wr0(4'd12, 8'hC2);
        wrrd0(4'd13, 8'hD0, "full_rd10", 4'd10, 8'hA0, 1'b1, 1'b1);
        wrrd0(4'd14, 8'hE0, "full_rd11", 4'd11, 8'hB1, 1'b1, 1'b1);
        rd0("full_rd12", 4'd12, 8'hC2, 1'b1, 1'b1);
        idle0();
        chk("pushpop_no_ovf", 32'(clr_ovf0), 32'h0);
        idle0();
        rd0("full_rd10_cleared", 4'd10, 8'h00, 1'b0, 1'b0);
        idle0();

        // Overflow: the third read under continuous writes is dropped
        wrrd0(4'd13, 8'hD1, "ovf_rd4", 4'd4, 8'h44, 1'b1, 1'b1);
        wrrd0(4'd14, 8'hE1, "ovf_rd5", 4'd5, 8'h55, 1'b1, 1'b1);
        wrrd0(4'd15, 8'hF5, "ovf_rd6", 4'd6, 8'h66, 1'b1, 1'b1);
        idle0();
        chk("ovf_flag_set", 32'(clr_ovf0), 32'h1);
        idle0();
        rd0("ovf_rd6_kept", 4'd6, 8'h66, 1'b1, 1'b1);
        rd0("ovf_rd4_cleared", 4'd4, 8'h00, 1'b0, 1'b0);
        rd0("ovf_rd5_cleared", 4'd5, 8'h00, 1'b0, 1'b0);
        idle0();

        // Flush while a clear is pending
        wr0(4'd0, 8'hF0); wr0(4'd1, 8'hF1); wr0(4'd2, 8'hF2); wr0(4'd3, 8'hF3);
        wrrd0(4'd9, 8'h99, "flush_pre_rd0", 4'd0, 8'hF0, 1'b1, 1'b1);
        d0(1'b1, 4'd9, 8'h99, 1'b0, '0, 1'b1);
        idle0();
        chk("flush_busy_rise", 32'(busy0), 32'h1);
        chk("flush_clr_ovf", 32'(clr_ovf0), 32'h0);
        measure_busy(nb);
        chk("flush_sweep_edges", 32'(nb), 32'd16);
        rd0("flush_rd0", 4'd0, 8'h00, 1'b0, 1'b1);
        rd0("flush_rd1", 4'd1, 8'h00, 1'b0, 1'b1);
        rd0("flush_rd2", 4'd2, 8'h00, 1'b0, 1'b1);
        rd0("flush_rd3", 4'd3, 8'h00, 1'b0, 1'b1);
        rd0("flush_rd9", 4'd9, 8'h00, 1'b0, 1'b1);
        idle0();
        idle0();

        // Sticky instance: reads never consume
        d1(1'b1, 4'd9, 8'h3C, 1'b0, '0);
        rd1("sticky_rd9_a", 4'd9, 8'h3C, 1'b1);
        rd1("sticky_rd9_b", 4'd9, 8'h3C, 1'b1);
        rd1("sticky_rd9_c", 4'd9, 8'h3C, 1'b1);
        d1(1'b0, '0, '0, 1'b0, '0);
        chk("sticky_clr_ovf", 32'(clr_ovf1), 32'h0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/replace_num_table.md
# replace_num_table

Parametrised replacement-number store for the test harness. UART-decoded writes load a data word plus valid flag per address; a read returns the word and flag and, in consume mode, schedules a clear of that flag so each replacement is used once. It replaces the fixed-size, unreset store: it adds an async reset with a RAM init sweep, a host flush command, a multi-entry clear queue with overflow reporting, and a sticky (non-consuming) mode.

## Interface
- DATA_WIDTH, 16: replacement data width.
- ADDR_WIDTH, 8: address width; depth = 2**ADDR_WIDTH.
- CLR_DEPTH, 2: pending-clear queue entries (≥1).
- STICKY, 0: 1 = reads never clear the valid flag.

Ports:
- clk  in  1  clock, all logic on rising edge.
- nrst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data; stored with valid=1.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- flush  in  1  one-cycle pulse; invalidate all entries.
- data_out  out  DATA_WIDTH  read data.
- valid_out  out  1  read entry valid.
- busy  out  1  init/flush sweep in progress.
- clr_ovf  out  1  sticky: a clear was lost to queue overflow.

## Operation
- Storage: dual-port RAM, DATA_WIDTH+1 bits (valid in MSB), read-first on same-address collision. Single RAM write port, arbitrated per cycle: sweep > user write > head of clear queue.
- FSM states SWEEP, RUN. nrst asserted -> SWEEP, sweep counter 0, queue empty. SWEEP writes {0,0} to address = counter each cycle; at counter = 2**ADDR_WIDTH-1 -> RUN. flush in RUN -> SWEEP, counter 0, queue emptied. flush in SWEEP restarts counter at 0.
- busy = 1 in SWEEP. During SWEEP wr_en is dropped; rd_en loads data_out=0, valid_out=0.
- RUN write: wr_en writes {1,wr_data} at wr_addr the same edge.
- RUN read: rd_en registers RAM word into data_out/valid_out. valid_out is forced 0 if rd_addr matches any pending queue entry. data_out/valid_out hold until next rd_en or sweep read.
- Consume (STICKY=0): each RUN rd_en pushes rd_addr into clear queue. Queue head issues a write of valid=0 (data field unchanged/don't-care) in any cycle with no wr_en; popped on issue.
- Supersede: an accepted wr_en to address A in the same cycle as, or after, a read of A deletes every pending clear entry for A; new data survives.
- Duplicate: read of an address already in the queue does not push again.
- Overflow: push to a full queue (not pop-same-cycle) drops the new entry, sets clr_ovf. clr_ovf cleared only by nrst or flush.
- Same-cycle push and pop with queue full: both happen, no overflow.
- STICKY=1: queue never pushed; clr_ovf stays 0.

## Timing
- Reset values: data_out 0, valid_out 0, busy 1, clr_ovf 0.
- Init/flush sweep: busy high exactly 2**ADDR_WIDTH cycles from the edge after nrst deassertion / flush pulse.
- Read latency 1: rd_en sampled at edge N, outputs valid after edge N.
- Write-to-read: write at edge N visible to a read sampled at edge N+1; read at edge N returns old contents.
- Clear issue: earliest the edge after the read edge, delayed by each cycle of wr_en; queue order FIFO.
- nrst mid-operation: all state cleared immediately; RAM contents recovered by sweep, not by reset.

## Test plan
- Reset (ADDR_WIDTH=4, DATA_WIDTH=8): release nrst -> busy high 16 cycles; then read addr 5 -> valid_out 0, data_out 0x00.
- Consume: write 0xA5 at 3, idle, read 3 -> data_out 0xA5, valid_out 1; idle, read 3 -> valid_out 0.
- Write-starved clear: write 0x11 at 2, read 2, then wr_en every cycle to 7/8/9 for 5 cycles, read 2 in 2nd cycle -> valid_out 0 (masked); after writes stop, clear commits, read 2 -> valid_out 0.
- Supersede/overflow (CLR_DEPTH=2): read 1, write 0x77 to 1 next cycle -> later read 1 gives 0x77 valid 1; with continuous writes, reads of 4,5,6 -> clr_ovf 1, entry 6 still valid.
- Flush: load addrs 0-3, pulse flush mid-clear-pending -> busy 16 cycles, clr_ovf 0, all reads valid_out 0.
- STICKY=1: write 0x3C at 9, read 9 three times -> valid_out 1, data_out 0x3C each time.
